// File: rtl/xbar_feeder.sv
// Staging and sequencing front end for the PE crossbar: serially loads one word per PE,
// then replays the bank for a programmed number of cycles with a chosen select pattern.
module xbar_feeder #(
  parameter int DATA_TYPE = 16,
  parameter int NUM_PES   = 16,
  parameter int LOG2_PES  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cfg_valid,
  input  logic [1:0]                    i_cfg_mode,
  input  logic [7:0]                    i_cfg_repeat,
  input  logic                          i_valid,
  input  logic [DATA_TYPE-1:0]          i_data,
  output logic                          o_ready,
  output logic [NUM_PES*DATA_TYPE-1:0]  o_data_bus,
  output logic [LOG2_PES*NUM_PES-1:0]   o_mux_bus,
  output logic                          o_bus_valid,
  output logic                          o_busy,
  output logic                          o_done
);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            mode_reg, mode_next;
  logic [7:0]            repeat_reg, repeat_next;
  logic [LOG2_PES-1:0]   load_idx_reg, load_idx_next;
  logic [7:0]            k_reg, k_next;
  logic                  done_reg, done_next;
  logic                  load_fire;

  assign load_fire = (state_reg == LOAD) && i_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= 2'd0;
      repeat_reg   <= 8'd1;
      load_idx_reg <= '0;
      k_reg        <= 8'd0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      repeat_reg   <= repeat_next;
      load_idx_reg <= load_idx_next;
      k_reg        <= k_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    repeat_next   = repeat_reg;
    load_idx_next = load_idx_reg;
    k_next        = k_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_cfg_valid) begin
          mode_next     = i_cfg_mode;
          repeat_next   = (i_cfg_repeat == 8'd0) ? 8'd1 : i_cfg_repeat;
          load_idx_next = '0;
          k_next        = 8'd0;
          state_next    = LOAD;
        end
      end
      LOAD: begin
        if (i_valid) begin
          load_idx_next = load_idx_reg + LOG2_PES'(1);
          if (load_idx_reg == LOG2_PES'(NUM_PES - 1)) begin
            k_next     = 8'd0;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (k_reg == repeat_reg - 8'd1) begin
          k_next     = 8'd0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          k_next = k_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_ready     = (state_reg == LOAD);
  assign o_bus_valid = (state_reg == ISSUE);
  assign o_busy      = (state_reg == LOAD) || (state_reg == ISSUE);
  assign o_done      = done_reg;

  // One register per slot so each can be written by its own load index match.
  for (genvar gi = 0; gi < NUM_PES; gi++) begin : g_slot
    logic [DATA_TYPE-1:0] slot_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_reg <= '0;
      end else if (load_fire && (load_idx_reg == LOG2_PES'(gi))) begin
        slot_reg <= i_data;
      end
    end
    assign o_data_bus[gi*DATA_TYPE +: DATA_TYPE] = slot_reg;
  end

  // Select arithmetic wraps naturally in LOG2_PES bits.
  for (genvar gi = 0; gi < NUM_PES; gi++) begin : g_sel
    logic [LOG2_PES-1:0] sel;
    always_comb begin
      sel = '0;
      if (state_reg == ISSUE) begin
        case (mode_reg)
          2'd0:    sel = LOG2_PES'(gi);
          2'd1:    sel = k_reg[LOG2_PES-1:0];
          2'd2:    sel = LOG2_PES'(gi) + k_reg[LOG2_PES-1:0];
          default: sel = LOG2_PES'(NUM_PES - 1 - gi);
        endcase
      end
    end
    assign o_mux_bus[gi*LOG2_PES +: LOG2_PES] = sel;
  end

endmodule

// File: tb/tb_xbar_feeder.sv
// Randomized job-level bench for xbar_feeder: each job is checked cycle by cycle
// against a bank model and select patterns computed directly from the mode rules.
module tb_xbar_feeder;
  localparam int DW = 16;
  localparam int NP = 16;
  localparam int LP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_cfg_valid = 1'b0;
  logic [1:0]        i_cfg_mode = '0;
  logic [7:0]        i_cfg_repeat = '0;
  logic              i_valid = 1'b0;
  logic [DW-1:0]     i_data = '0;
  logic              o_ready;
  logic [NP*DW-1:0]  o_data_bus;
  logic [LP*NP-1:0]  o_mux_bus;
  logic              o_bus_valid;
  logic              o_busy;
  logic              o_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] mb [NP];

  xbar_feeder #(.DATA_TYPE(DW), .NUM_PES(NP), .LOG2_PES(LP)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_valid(i_cfg_valid), .i_cfg_mode(i_cfg_mode), .i_cfg_repeat(i_cfg_repeat),
    .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_data_bus(o_data_bus), .o_mux_bus(o_mux_bus),
    .o_bus_valid(o_bus_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NP*DW-1:0] bank_flat();
    logic [NP*DW-1:0] f;
    for (int j = 0; j < NP; j++) f[j*DW +: DW] = mb[j];
    return f;
  endfunction

  function automatic logic [NP*LP-1:0] exp_mux(input int mode, input int k);
    logic [NP*LP-1:0] m;
    int s;
    m = '0;
    for (int i = 0; i < NP; i++) begin
      case (mode)
        0:       s = i;
        1:       s = k % NP;
        2:       s = (i + k) % NP;
        default: s = NP - 1 - i;
      endcase
      m[i*LP +: LP] = LP'(s);
    end
    return m;
  endfunction

  // stall: 0 none, 1 alternate, 2 random. abort: issue index at which rst hits (-1 none).
  task automatic run_job(input int mode, input int rep, input int stall, input bit pat,
                         input bit glitch, input bit b2b, input int abort, input int gap);
    int r;
    int idx;
    int cyc;
    bit v;
    logic [DW-1:0] w [NP];
    r = (rep == 0) ? 1 : rep;
    idx = 0;
    cyc = 0;
    for (int j = 0; j < NP; j++) w[j] = pat ? DW'(16'h1000 + j) : DW'($urandom);
    for (int g = 0; g < gap; g++) begin
      i_valid = 1'($urandom);
      i_data  = DW'($urandom);
      check("idle_busy", o_busy, 0);
      check("idle_ready", o_ready, 0);
      check("idle_bank", o_data_bus, bank_flat());
      @(negedge clk);
    end
    i_cfg_valid  = 1'b1;
    i_cfg_mode   = 2'(mode);
    i_cfg_repeat = 8'(rep);
    i_valid      = 1'b0;
    @(negedge clk);
    while (idx < NP && cyc < 200) begin
      check("load_ready", o_ready, 1);
      check("load_busy", o_busy, 1);
      check("load_valid", o_bus_valid, 0);
      check("load_mux", o_mux_bus, 0);
      check("load_bank", o_data_bus, bank_flat());
      i_cfg_valid  = glitch ? 1'($urandom) : 1'b0;
      i_cfg_mode   = 2'($urandom);
      i_cfg_repeat = 8'($urandom);
      case (stall)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom);
      endcase
      i_valid = v;
      i_data  = w[idx];
      @(negedge clk);
      cyc++;
      if (v) begin
        mb[idx] = w[idx];
        idx++;
      end
    end
    check("load_count", idx, NP);
    for (int kk = 0; kk < r; kk++) begin
      if (kk == abort) begin
        rst = 1'b1;
        i_cfg_valid = 1'b0;
        i_valid = 1'b0;
        #1;
        for (int j = 0; j < NP; j++) mb[j] = '0;
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_bus_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_mux", o_mux_bus, 0);
        check("rst_bank", o_data_bus, bank_flat());
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("rst_nodone", o_done, 0);
          check("rst_idle", o_busy, 0);
        end
        $display("job mode=%0d rep=%0d aborted by reset at issue %0d", mode, rep, kk);
        return;
      end
      check("issue_valid", o_bus_valid, 1);
      check("issue_ready", o_ready, 0);
      check("issue_busy", o_busy, 1);
      check("issue_done", o_done, 0);
      check("issue_mux", o_mux_bus, exp_mux(mode, kk));
      check("issue_bank", o_data_bus, bank_flat());
      i_cfg_valid  = glitch ? 1'($urandom) : 1'b0;
      i_cfg_mode   = 2'($urandom);
      i_cfg_repeat = 8'($urandom);
      i_valid      = 1'($urandom);
      i_data       = DW'($urandom);
      @(negedge clk);
    end
    i_cfg_valid = 1'b0;
    i_valid     = 1'b0;
    check("done_pulse", o_done, 1);
    check("done_busy", o_busy, 0);
    check("done_valid", o_bus_valid, 0);
    check("done_ready", o_ready, 0);
    check("done_mux", o_mux_bus, 0);
    check("done_bank", o_data_bus, bank_flat());
    $display("job mode=%0d rep=%0d stall=%0d load_cycles=%0d issued=%0d b2b=%0d", mode, rep, stall, cyc, r, b2b);
    if (!b2b) begin
      @(negedge clk);
      check("done_clear", o_done, 0);
    end
  endtask

  initial begin
    for (int j = 0; j < NP; j++) mb[j] = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", o_ready, 0);
    check("reset_valid", o_bus_valid, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_mux", o_mux_bus, 0);
    check("reset_bank", o_data_bus, 0);
    rst = 1'b0;
    @(negedge clk);

    run_job(1, 5, 2, 1'b0, 1'b0, 1'b0, 2, 1);   // reset during issue
    run_job(0, 0, 0, 1'b1, 1'b0, 1'b0, -1, 1);  // identity, repeat 0
    run_job(1, 18, 0, 1'b0, 1'b0, 1'b0, -1, 0); // broadcast past NUM_PES
    run_job(2, 3, 1, 1'b0, 1'b0, 1'b0, -1, 2);  // rotate with stalls
    run_job(3, 2, 2, 1'b0, 1'b1, 1'b0, -1, 0);  // reverse with ignored configs
    run_job(2, 4, 0, 1'b0, 1'b0, 1'b1, -1, 0);  // back-to-back pair
    run_job(0, 1, 2, 1'b0, 1'b0, 1'b0, -1, 0);
    for (int n = 0; n < 12; n++) begin
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
              1'b0, 1'($urandom), 1'($urandom), -1, int'($urandom_range(0, 3)));
    end
    run_job(2, 20, 2, 1'b0, 1'b1, 1'b0, -1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xbar_feeder.md
# xbar_feeder

Upstream staging and sequencing stage for the PE distribution crossbar. Accepts a serial stream of operand words through a valid/ready handshake and assembles NUM_PES words into a staging bank. It then drives the crossbar's data bus and per-PE mux-select bus for a programmed number of issue cycles, using one of four select patterns. One configuration, one load, then one issue burst per job.

## Interface

- DATA_TYPE, 16: width of one operand word.
- NUM_PES, 16: number of PEs and number of staging slots; power of two.
- LOG2_PES, 4: log2(NUM_PES); width of one mux select.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_cfg_valid  in  1  configuration strobe; honoured only in IDLE.
- i_cfg_mode  in  2  select pattern: 0 identity, 1 broadcast, 2 rotate, 3 reverse.
- i_cfg_repeat  in  8  number of issue cycles; 0 is treated as 1.
- i_valid  in  1  operand word valid.
- i_data  in  DATA_TYPE  operand word.
- o_ready  out  1  high in LOAD only.
- o_data_bus  out  NUM_PES*DATA_TYPE  staging bank; slot j at bits [j*DATA_TYPE +: DATA_TYPE].
- o_mux_bus  out  LOG2_PES*NUM_PES  select for PE i at bits [i*LOG2_PES +: LOG2_PES].
- o_bus_valid  out  1  high in every ISSUE cycle.
- o_busy  out  1  high in LOAD or ISSUE.
- o_done  out  1  one-cycle pulse after the last issue cycle.

## Operation

- States: IDLE, LOAD, ISSUE.
- IDLE: if i_cfg_valid is high, latch mode and repeat (0 becomes 1), clear the load index, and go to LOAD.
- LOAD: o_ready=1. Each cycle with i_valid=1 writes i_data to slot[load_idx] and increments load_idx. The accept on load_idx=NUM_PES-1 moves to ISSUE. i_valid=0 stalls with no state change.
- ISSUE: the issue counter k runs 0..repeat-1, one value per cycle. The cycle with k=repeat-1 returns to IDLE and sets o_done for the following cycle.
- Select for PE i, with arithmetic mod NUM_PES (LOG2_PES-bit wrap):
  - mode 0: sel=i.
  - mode 1: sel=k mod NUM_PES.
  - mode 2: sel=(i+k) mod NUM_PES.
  - mode 3: sel=NUM_PES-1-i.
- o_mux_bus is decoded from the registered mode and k. It is all zeros outside ISSUE.
- o_data_bus always shows the staging bank. The bank holds its contents after ISSUE until it is overwritten by the next LOAD or by reset.
- i_cfg_valid outside IDLE is ignored, with no side effects. i_valid outside LOAD is ignored, and no word is stored.
- repeat counts above NUM_PES are allowed. k wraps only in the select arithmetic; the counter itself is 8 bits wide.

## Timing

- Reset (async assert, any state): state=IDLE and all staging slots=0. o_ready=0, o_bus_valid=0, o_busy=0, o_done=0, o_mux_bus=0, latched mode=0, repeat=1, counters=0.
- Reset mid-LOAD or mid-ISSUE discards the job. No o_done is produced.
- Config accepted at edge c: LOAD and o_ready=1 from cycle c+1.
- Last word accepted at edge t: ISSUE from cycle t+1. o_bus_valid=1 for exactly `repeat` consecutive cycles, t+1 .. t+repeat.
- o_done=1 in cycle t+repeat+1, in which state is already IDLE. A new config presented in that same cycle is accepted.
- Minimum job length from config to done: 1 + NUM_PES + repeat + 1 cycles.
- Handshake: a transfer occurs when i_valid and o_ready are both high at a rising edge. o_ready does not depend combinationally on i_valid.

## Test plan

- **Reset:** assert rst during ISSUE of a running job → next cycle every output is 0, state IDLE, o_done never pulses. After release, a fresh job runs normally.
- **Identity, repeat=0:** load words 0x1000+j, j=0..15, with no gaps → o_ready drops after 16 accepts. Exactly 1 cycle of o_bus_valid with sel[i]=i and slot j=0x1000+j, then o_done one cycle later.
- **Broadcast, repeat=18:** over 18 valid cycles every PE select equals k mod 16, i.e. 0..15 then 0,1. o_busy is low in the o_done cycle.
- **Rotate with stalls, repeat=3:** load with i_valid toggling every other cycle → the bank is still exactly in order. Issue cycles give PE 5 selects 5, 6, 7; PE 15 gives 15, 0, 1.
- **Reverse, repeat=2:** sel[0]=15 and sel[15]=0 for both cycles. i_cfg_valid pulsed during LOAD and ISSUE is ignored, leaving mode and repeat unchanged.
- **Back-to-back:** second config presented in the o_done cycle → LOAD begins the next cycle. o_data_bus keeps the old words until they are overwritten slot by slot.
